// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed receive path: FSM states,
// line-state codes, SYNC pattern and the default clocks-per-bit.
package usb_pkg;

    localparam int unsigned USB_SPB = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_DATA  = 3'd2,
        ST_EOP   = 3'd3,
        ST_ABORT = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        LINE_SE0 = 2'd0,
        LINE_J   = 2'd1,
        LINE_K   = 2'd2
    } line_e;

    // Decoded SYNC bits in arrival order (bit 0 first): seven 0s then a 1.
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    // Idle-J value of the synchronized {dp, dn, dif} bundle.
    localparam logic [2:0] LINE_RST = 3'b101;

    function automatic line_e line_decode(input logic dp, input logic dn, input logic dif);
        line_e res;
        if (!dp && !dn) begin
            res = LINE_SE0;
        end else if (dif) begin
            res = LINE_J;
        end else begin
            res = LINE_K;
        end
        return res;
    endfunction

endpackage

// File: rtl/usb_rxsync.sv
// Multi-flop synchronizer for a bundle of asynchronous line inputs,
// reset to a caller-supplied idle value.
module usb_rxsync
    import usb_pkg::*;
#(
    parameter int unsigned          WIDTH   = 3,
    parameter int unsigned          STAGES  = 2,
    parameter logic [WIDTH-1:0]     RST_VAL = LINE_RST
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift chain; stage 0 is the only flop that sees the asynchronous input.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                sync_q[i] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/usb_rxphy.sv
// Full-speed USB receive PHY: line sync, mid-bit sampling, NRZI decode,
// SYNC/EOP framing and bit unstuffing. Macro USB_RXPHY_STUFFERR_EN enables stuff-error abort.
module usb_rxphy
    import usb_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned SPB         = USB_SPB
) (
    input  logic clk,
    input  logic rstn,
    input  logic rx_dp,
    input  logic rx_dn,
    input  logic rx_dif,
    output logic rx_active,
    output logic bit_strb,
    output logic bit_val,
    output logic eop_strb,
    output logic stuff_err
);

    localparam int unsigned     PH_W    = $clog2(SPB);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SPB - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(SPB / 2);

    logic [2:0]      line_sync_s;
    line_e           line_s;
    line_e           line_prev_q;
    line_e           lvl_q, lvl_d;
    rx_state_e       state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_s, phase_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [2:0]      ones_q, ones_d;
    logic            jk_edge_s, smp_s, se0_smp_s, jk_smp_s, dec_s;
    logic            rx_active_q, rx_active_d;
    logic            bit_strb_q, bit_strb_d;
    logic            bit_val_q, bit_val_d;
    logic            eop_strb_q, eop_strb_d;
`ifdef USB_RXPHY_STUFFERR_EN
    logic            stuff_err_q, stuff_err_d;
`endif

    usb_rxsync #(
        .WIDTH   (3),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (LINE_RST)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  ({rx_dp, rx_dn, rx_dif}),
        .q_o  (line_sync_s)
    );

    assign line_s = line_decode(line_sync_s[2], line_sync_s[1], line_sync_s[0]);

    // Bit-phase tracking: a J<->K edge restarts the bit, sample at mid-bit.
    always_comb begin
        jk_edge_s = ((line_s == LINE_J) && (line_prev_q == LINE_K)) ||
                    ((line_s == LINE_K) && (line_prev_q == LINE_J));
        if (jk_edge_s) begin
            phase_s = '0;
        end else begin
            phase_s = phase_q;
        end
        if (phase_s == PH_LAST) begin
            phase_d = '0;
        end else begin
            phase_d = phase_s + PH_W'(1);
        end
        smp_s     = (phase_s == PH_MID);
        se0_smp_s = smp_s && (line_s == LINE_SE0);
        jk_smp_s  = smp_s && (line_s != LINE_SE0);
        dec_s     = (line_s == lvl_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus SYNC/SE0/ones counters and the NRZI reference level.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ones_d  = ones_q;
        if (jk_smp_s) begin
            lvl_d = line_s;
        end else begin
            lvl_d = lvl_q;
        end
        case (state_q)
            ST_IDLE: begin
                cnt_d  = 3'd0;
                ones_d = 3'd0;
                if (jk_smp_s && (line_s == LINE_K)) begin
                    state_d = ST_SYNC;
                    cnt_d   = 3'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (se0_smp_s) begin
                    state_d = ST_IDLE;
                end else if (jk_smp_s) begin
                    if (dec_s != SYNC_PATTERN[cnt_q]) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == 3'd7) begin
                        state_d = ST_DATA;
                        ones_d  = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_SYNC;
                end
            end
            ST_DATA: begin
                if (se0_smp_s) begin
                    state_d = ST_EOP;
                    cnt_d   = 3'd1;
                    ones_d  = 3'd0;
                end else if (jk_smp_s) begin
                    if (!dec_s) begin
                        ones_d = 3'd0;
                    end else if (ones_q == 3'd6) begin
`ifdef USB_RXPHY_STUFFERR_EN
                        state_d = ST_ABORT;
                        cnt_d   = 3'd0;
`else
                        ones_d  = 3'd6;
`endif
                    end else begin
                        ones_d = ones_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_EOP: begin
                if (se0_smp_s) begin
                    if (cnt_q == 3'd2) begin
                        state_d = ST_ABORT;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (jk_smp_s) begin
                    if (line_s == LINE_J) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ABORT;
                        cnt_d   = 3'd0;
                    end
                end else begin
                    state_d = ST_EOP;
                end
            end
            ST_ABORT: begin
                // cnt_q==1 marks "SE0 seen"; only SE0 followed by J releases.
                if (se0_smp_s) begin
                    cnt_d = 3'd1;
                end else if (jk_smp_s) begin
                    if ((line_s == LINE_J) && (cnt_q == 3'd1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = 3'd0;
                    end
                end else begin
                    state_d = ST_ABORT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
                ones_d  = 3'd0;
            end
        endcase
        if (state_d == ST_IDLE) begin
            lvl_d = LINE_J;
        end else begin
            lvl_d = lvl_d;
        end
    end

    // Output decode from the current state and this cycle's sample.
    always_comb begin
        bit_strb_d = 1'b0;
        bit_val_d  = 1'b0;
        eop_strb_d = 1'b0;
`ifdef USB_RXPHY_STUFFERR_EN
        stuff_err_d = 1'b0;
`endif
        rx_active_d = (state_d == ST_DATA) || (state_d == ST_EOP);
        if ((state_q == ST_DATA) && jk_smp_s) begin
            if (!dec_s) begin
                bit_strb_d = (ones_q != 3'd6);
                bit_val_d  = 1'b0;
            end else if (ones_q == 3'd6) begin
`ifdef USB_RXPHY_STUFFERR_EN
                stuff_err_d = 1'b1;
`else
                bit_strb_d  = 1'b1;
                bit_val_d   = 1'b1;
`endif
            end else begin
                bit_strb_d = 1'b1;
                bit_val_d  = 1'b1;
            end
        end else if ((state_q == ST_EOP) && jk_smp_s && (line_s == LINE_J)) begin
            eop_strb_d = 1'b1;
        end else begin
            eop_strb_d = 1'b0;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            line_prev_q <= LINE_J;
            lvl_q       <= LINE_J;
            phase_q     <= '0;
            cnt_q       <= 3'd0;
            ones_q      <= 3'd0;
            rx_active_q <= 1'b0;
            bit_strb_q  <= 1'b0;
            bit_val_q   <= 1'b0;
            eop_strb_q  <= 1'b0;
        end else begin
            line_prev_q <= line_s;
            lvl_q       <= lvl_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            ones_q      <= ones_d;
            rx_active_q <= rx_active_d;
            bit_strb_q  <= bit_strb_d;
            bit_val_q   <= bit_val_d;
            eop_strb_q  <= eop_strb_d;
        end
    end

`ifdef USB_RXPHY_STUFFERR_EN
    // Stuff-error pulse register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stuff_err_q <= 1'b0;
        end else begin
            stuff_err_q <= stuff_err_d;
        end
    end
    assign stuff_err = stuff_err_q;
`else
    assign stuff_err = 1'b0;
`endif

    assign rx_active = rx_active_q;
    assign bit_strb  = bit_strb_q;
    assign bit_val   = bit_val_q;
    assign eop_strb  = eop_strb_q;

endmodule

// File: doc/usb_rxphy.md
USB_RXPHY -- requirements
Module: usb_rxphy

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on each line input, minimum 2.
REQ-002 SHALL have parameter SPB, default 4: clk cycles per USB bit (48 MHz clk for 12 Mb/s full speed), fixed at 4 in this revision.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn, input, 1: reset; synchronous and active-low.
REQ-005 SHALL have port rx_dp, input, 1: D+ single-ended receiver output, asynchronous to clk.
REQ-006 SHALL have port rx_dn, input, 1: D- single-ended receiver output, asynchronous to clk.
REQ-007 SHALL have port rx_dif, input, 1: differential receiver output (1=J, 0=K), asynchronous to clk.
REQ-008 SHALL have port rx_active, output, 1: high from the cycle after the SYNC last bit until EOP or abort.
REQ-009 SHALL have port bit_strb, output, 1: one-cycle pulse, one per recovered unstuffed data bit.
REQ-010 SHALL have port bit_val, output, 1: decoded bit value, valid only while bit_strb=1.
REQ-011 SHALL have port eop_strb, output, 1: one-cycle pulse on a valid EOP that ends a packet.
REQ-012 SHALL have port stuff_err, output, 1: one-cycle pulse on a bit-stuff violation.

Function
REQ-013 SHALL pass rx_dp, rx_dn and rx_dif through SYNC_STAGES flops; all later logic uses only the synchronized values.
REQ-014 SHALL classify the line each cycle: SE0 = dp=0 and dn=0; otherwise J when dif=1 and K when dif=0.
REQ-015 SHALL run a phase counter 0..SPB-1 that wraps from 3 to 0 and resets to 0 on every synchronized J/K transition.
REQ-016 SHALL sample the line once per bit, at phase 2 (mid-bit).
REQ-017 SHALL NRZI-decode each sample: 1 if the level equals the previous sampled level, 0 if it differs; the previous level is J at IDLE entry.
REQ-018 SHALL implement states IDLE, SYNC, DATA, EOP and ABORT.
REQ-019 IDLE: on a K sample, go to SYNC with a decoded-bit count of 1 (first 0); stay in IDLE on J or SE0.
REQ-020 SYNC: the decoded bits must match 0000000 followed by 1; on the final 1 go to DATA and assert rx_active on the next cycle.
REQ-021 SYNC: any mismatching bit or any SE0 sample returns to IDLE, with no output pulses.
REQ-022 DATA: keep a count of consecutive 1s; a 0 that follows six 1s is a stuffed bit, is dropped (no bit_strb) and clears the count.
REQ-023 DATA: every other decoded bit asserts bit_strb with bit_val for exactly one cycle; latency is 1 cycle from the sampling cycle.
REQ-024 DATA: an SE0 sample goes to EOP; no bit_strb is issued for that sample, and a partial ones count is discarded.
REQ-025 EOP: a J sample after 1 or 2 SE0 samples pulses eop_strb, drops rx_active in the same cycle and goes to IDLE.
REQ-026 EOP: a K sample, or a 3rd consecutive SE0 sample, drops rx_active and goes to ABORT without eop_strb.
REQ-027 ABORT: leave for IDLE only after an SE0 sample followed by a J sample; no pulses while in ABORT.
REQ-028 bit_strb, eop_strb and stuff_err SHALL be mutually exclusive in any cycle.

Reset
REQ-029 rstn=0 at a rising clk edge SHALL, on that edge: set the state to IDLE, zero all outputs, counters and the phase, set the synchronizer flops and previous level to J (dp=1, dn=0, dif=1), and abandon any packet in progress without eop_strb.

Configuration
REQ-030 Macro USB_RXPHY_STUFFERR_EN defined: in DATA, a seventh consecutive decoded 1 SHALL pulse stuff_err, drop rx_active and go to ABORT.
REQ-031 Macro USB_RXPHY_STUFFERR_EN undefined: stuff_err SHALL be tied 0 and the seventh 1 SHALL be delivered as a normal data bit with the ones count held at 6.

Structure
REQ-032 Shared package usb_pkg SHALL hold the state encoding, the J/K/SE0 line-state codes, the SYNC pattern constant and SPB.
REQ-033 The synchronizer SHALL be a separate sub-module, usb_rxsync, with a width parameter and SYNC_STAGES; one instance carries dp, dn and dif.

Verification
REQ-034 Drive idle J, then SYNC KJKJKJKK, then NRZI data 0xA5 (LSB first), then SE0 SE0 J -> rx_active high, 8 bit_strb pulses with bit_val 1,0,1,0,0,1,0,1, one eop_strb, rx_active low.
REQ-035 Drive data byte 0xFF with a stuffed 0 after six 1s -> 8 bit_strb pulses, all bit_val=1, and no pulse for the stuffed bit.
REQ-036 Drive seven consecutive 1s with the macro defined -> stuff_err pulses once and rx_active falls; with the macro undefined -> 7 bit_strb pulses and stuff_err stays 0.
REQ-037 Drive a SYNC corrupted at bit 4 (KJKK...) -> return to IDLE, rx_active stays 0, and no bit_strb pulses.
REQ-038 Drive bit periods alternating 3 and 5 clk cycles (+/-1 cycle jitter) during a 0x3C payload -> all 8 bits recovered correctly.
REQ-039 Assert rstn=0 for one cycle mid-DATA -> all outputs 0 on the next edge, no eop_strb, and the next SYNC is received normally.
